// File: rtl/bp_sacc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_sacc_mem_arbiter
// Brief    : Routes a BedRock forward stream to one of several accelerator
//            ports and round-robin merges their response streams back.
//            Optional stall counter: BP_SACC_MEM_ARBITER_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_sacc_mem_arbiter #(
    parameter int num_acc_p         = 2,
    parameter int hdr_width_p       = 64,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4,
    localparam int sel_width_lp     = $clog2(num_acc_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [hdr_width_p-1:0]            mem_fwd_header_i,
    input  logic [data_width_p-1:0]           mem_fwd_data_i,
    input  logic                              mem_fwd_v_i,
    input  logic                              mem_fwd_last_i,
    input  logic [sel_width_lp:0]             mem_fwd_dst_i,
    output logic                              mem_fwd_ready_and_o,

    output logic [num_acc_p*hdr_width_p-1:0]  acc_fwd_header_o,
    output logic [num_acc_p*data_width_p-1:0] acc_fwd_data_o,
    output logic [num_acc_p-1:0]              acc_fwd_v_o,
    output logic [num_acc_p-1:0]              acc_fwd_last_o,
    input  logic [num_acc_p-1:0]              acc_fwd_ready_and_i,

    input  logic [num_acc_p*hdr_width_p-1:0]  acc_rev_header_i,
    input  logic [num_acc_p*data_width_p-1:0] acc_rev_data_i,
    input  logic [num_acc_p-1:0]              acc_rev_v_i,
    input  logic [num_acc_p-1:0]              acc_rev_last_i,
    output logic [num_acc_p-1:0]              acc_rev_ready_and_o,

    output logic [hdr_width_p-1:0]            mem_rev_header_o,
    output logic [data_width_p-1:0]           mem_rev_data_o,
    output logic                              mem_rev_v_o,
    output logic                              mem_rev_last_o,
    input  logic                              mem_rev_ready_and_i,

    output logic                              err_o,
    output logic [31:0]                       stall_cnt_o
);

    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_stream = 2'd1;
    localparam logic [1:0] c_st_drop   = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [sel_width_lp-1:0] r_dst;
    logic [cnt_width_lp-1:0] r_cnt;
    logic                    r_err;

    logic                    w_dst_ok;
    logic                    w_cnt_full;
    logic                    w_route;
    logic [sel_width_lp-1:0] w_route_idx;
    logic                    w_fwd_ready;
    logic                    w_bad_dst;
    logic                    w_fwd_hs;
    logic                    w_inc;

    logic                    r_rr_locked;
    logic [sel_width_lp-1:0] r_rr_ptr;
    logic [sel_width_lp-1:0] r_rr_grant;
    logic                    w_rr_found;
    logic [sel_width_lp-1:0] w_rr_idx;
    logic [sel_width_lp-1:0] w_cand;
    logic [sel_width_lp-1:0] w_rev_sel;
    logic [sel_width_lp-1:0] w_rev_sel_nxt;
    logic                    w_rev_any;
    logic                    w_rev_hs;
    logic                    w_dec;

    assign w_dst_ok   = (mem_fwd_dst_i < (sel_width_lp+1)'(num_acc_p));
    // Registered count: a response landing in the same cycle cannot release the stall.
    assign w_cnt_full = (r_cnt == cnt_width_lp'(max_outstanding_p));

    always_comb begin
        w_route     = 1'b0;
        w_route_idx = r_dst;
        w_fwd_ready = 1'b0;
        w_bad_dst   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (mem_fwd_v_i) begin
                    if (!w_dst_ok) begin
                        w_bad_dst   = 1'b1;
                        w_fwd_ready = 1'b1;
                        if (!mem_fwd_last_i) w_state_nxt = c_st_drop;
                    end else if (!w_cnt_full) begin
                        w_route     = 1'b1;
                        w_route_idx = mem_fwd_dst_i[sel_width_lp-1:0];
                        w_fwd_ready = acc_fwd_ready_and_i[w_route_idx];
                        if (w_fwd_ready && !mem_fwd_last_i) w_state_nxt = c_st_stream;
                    end
                end
            end
            c_st_stream: begin
                if (mem_fwd_v_i) begin
                    w_route     = 1'b1;
                    w_fwd_ready = acc_fwd_ready_and_i[r_dst];
                    if (w_fwd_ready && mem_fwd_last_i) w_state_nxt = c_st_idle;
                end
            end
            c_st_drop: begin
                if (mem_fwd_v_i) begin
                    w_fwd_ready = 1'b1;
                    if (mem_fwd_last_i) w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    assign w_fwd_hs = mem_fwd_v_i & w_fwd_ready;
    assign w_inc    = w_route & w_fwd_hs & mem_fwd_last_i;

    assign mem_fwd_ready_and_o = w_fwd_ready & ~reset_i;
    assign acc_fwd_header_o    = {num_acc_p{mem_fwd_header_i}};
    assign acc_fwd_data_o      = {num_acc_p{mem_fwd_data_i}};
    assign acc_fwd_last_o      = {num_acc_p{mem_fwd_last_i}};

    always_comb begin
        acc_fwd_v_o = '0;
        for (int i = 0; i < num_acc_p; i++) begin
            acc_fwd_v_o[i] = w_route & ~reset_i & (int'(w_route_idx) == i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
            r_dst   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_idle && w_route && w_fwd_hs) r_dst <= w_route_idx;
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo the port count.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int i = 0; i < num_acc_p; i++) begin
            w_cand = sel_width_lp'((int'(r_rr_ptr) + i) % num_acc_p);
            if (!w_rr_found && acc_rev_v_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    assign w_rev_sel     = r_rr_locked ? r_rr_grant : w_rr_idx;
    assign w_rev_any     = r_rr_locked | w_rr_found;
    assign w_rev_sel_nxt = (int'(w_rev_sel) == num_acc_p - 1) ? '0
                                                               : w_rev_sel + sel_width_lp'(1);

    assign mem_rev_v_o      = w_rev_any & acc_rev_v_i[w_rev_sel] & ~reset_i;
    assign mem_rev_header_o = acc_rev_header_i[w_rev_sel*hdr_width_p +: hdr_width_p];
    assign mem_rev_data_o   = acc_rev_data_i[w_rev_sel*data_width_p +: data_width_p];
    assign mem_rev_last_o   = acc_rev_last_i[w_rev_sel];

    assign w_rev_hs = mem_rev_v_o & mem_rev_ready_and_i;
    assign w_dec    = w_rev_hs & mem_rev_last_o;

    always_comb begin
        acc_rev_ready_and_o = '0;
        for (int i = 0; i < num_acc_p; i++) begin
            acc_rev_ready_and_o[i] = w_rev_any & mem_rev_ready_and_i & ~reset_i
                                   & (int'(w_rev_sel) == i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rr_locked <= 1'b0;
            r_rr_ptr    <= '0;
            r_rr_grant  <= '0;
        end else if (w_rev_hs) begin
            if (mem_rev_last_o) begin
                r_rr_locked <= 1'b0;
                r_rr_ptr    <= w_rev_sel_nxt;
            end else begin
                r_rr_locked <= 1'b1;
                r_rr_grant  <= w_rev_sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_bad_dst) r_err <= 1'b1;
            if (w_inc && !w_dec && !w_cnt_full) begin
                r_cnt <= r_cnt + cnt_width_lp'(1);
            end else if (w_dec && !w_inc) begin
                if (r_cnt == '0) r_err <= 1'b1;
                else             r_cnt <= r_cnt - cnt_width_lp'(1);
            end
        end
    end

    assign err_o = r_err;

`ifdef BP_SACC_MEM_ARBITER_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (mem_fwd_v_i && !mem_fwd_ready_and_o) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_sacc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_sacc_mem_arbiter
// Brief    : Vector-table bench for bp_sacc_mem_arbiter plus reset, underflow
//            and round-robin sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_sacc_mem_arbiter;

    localparam int N  = 2;
    localparam int HW = 64;
    localparam int DW = 64;
    localparam int MO = 4;
`ifdef BP_SACC_MEM_ARBITER_PERF_EN
    localparam int EXP_STALL = 3;
`else
    localparam int EXP_STALL = 0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [HW-1:0] mem_fwd_header_i;
    logic [DW-1:0] mem_fwd_data_i;
    logic          mem_fwd_v_i;
    logic          mem_fwd_last_i;
    logic [1:0]    mem_fwd_dst_i;
    logic          mem_fwd_ready_and_o;
    logic [N*HW-1:0] acc_fwd_header_o;
    logic [N*DW-1:0] acc_fwd_data_o;
    logic [N-1:0]  acc_fwd_v_o;
    logic [N-1:0]  acc_fwd_last_o;
    logic [N-1:0]  acc_fwd_ready_and_i;
    logic [N*HW-1:0] acc_rev_header_i;
    logic [N*DW-1:0] acc_rev_data_i;
    logic [N-1:0]  acc_rev_v_i;
    logic [N-1:0]  acc_rev_last_i;
    logic [N-1:0]  acc_rev_ready_and_o;
    logic [HW-1:0] mem_rev_header_o;
    logic [DW-1:0] mem_rev_data_o;
    logic          mem_rev_v_o;
    logic          mem_rev_last_o;
    logic          mem_rev_ready_and_i;
    logic          err_o;
    logic [31:0]   stall_cnt_o;

    always #5 clk_i = ~clk_i;

    bp_sacc_mem_arbiter #(
        .num_acc_p        (N),
        .hdr_width_p      (HW),
        .data_width_p     (DW),
        .max_outstanding_p(MO)
    ) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .mem_fwd_header_i   (mem_fwd_header_i),
        .mem_fwd_data_i     (mem_fwd_data_i),
        .mem_fwd_v_i        (mem_fwd_v_i),
        .mem_fwd_last_i     (mem_fwd_last_i),
        .mem_fwd_dst_i      (mem_fwd_dst_i),
        .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
        .acc_fwd_header_o   (acc_fwd_header_o),
        .acc_fwd_data_o     (acc_fwd_data_o),
        .acc_fwd_v_o        (acc_fwd_v_o),
        .acc_fwd_last_o     (acc_fwd_last_o),
        .acc_fwd_ready_and_i(acc_fwd_ready_and_i),
        .acc_rev_header_i   (acc_rev_header_i),
        .acc_rev_data_i     (acc_rev_data_i),
        .acc_rev_v_i        (acc_rev_v_i),
        .acc_rev_last_i     (acc_rev_last_i),
        .acc_rev_ready_and_o(acc_rev_ready_and_o),
        .mem_rev_header_o   (mem_rev_header_o),
        .mem_rev_data_o     (mem_rev_data_o),
        .mem_rev_v_o        (mem_rev_v_o),
        .mem_rev_last_o     (mem_rev_last_o),
        .mem_rev_ready_and_i(mem_rev_ready_and_i),
        .err_o              (err_o),
        .stall_cnt_o        (stall_cnt_o)
    );

    typedef struct {
        logic       fv;
        logic       fl;
        logic [1:0] dst;
        logic [1:0] ar;
        logic [1:0] rv;
        logic [1:0] rl;
        logic       mr;
        logic       e_fr;
        logic [1:0] e_av;
        logic       e_mv;
        logic [1:0] e_arr;
        logic       e_err;
        int         e_src;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic fl, input logic [1:0] dst,
                       input logic [1:0] ar, input logic [1:0] rv, input logic [1:0] rl,
                       input logic mr, input logic e_fr, input logic [1:0] e_av,
                       input logic e_mv, input logic [1:0] e_arr, input logic e_err,
                       input int e_src);
        vec_t v;
        v.fv = fv; v.fl = fl; v.dst = dst; v.ar = ar; v.rv = rv; v.rl = rl; v.mr = mr;
        v.e_fr = e_fr; v.e_av = e_av; v.e_mv = e_mv; v.e_arr = e_arr;
        v.e_err = e_err; v.e_src = e_src;
        vecs.push_back(v);
    endtask

    task automatic drive_idle;
        mem_fwd_v_i         = 1'b0;
        mem_fwd_last_i      = 1'b0;
        mem_fwd_dst_i       = 2'd0;
        acc_fwd_ready_and_i = 2'b00;
        acc_rev_v_i         = 2'b00;
        acc_rev_last_i      = 2'b00;
        mem_rev_ready_and_i = 1'b0;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        drive_idle();
        @(posedge clk_i);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    function automatic logic [63:0] rev_hdr(input int p);
        return 64'hAAAA_0000_0000_0000 + 64'(p);
    endfunction

    initial begin
        logic [1:0] beat;
        int         src;

        mem_fwd_header_i = '0;
        mem_fwd_data_i   = '0;
        acc_rev_header_i = {rev_hdr(1), rev_hdr(0)};
        acc_rev_data_i   = {64'hDDDD_0000_0000_0001, 64'hDDDD_0000_0000_0000};

        // fv fl dst ar rv rl mr | fr av mv arr err src
        add(1,1,2'd1,2'b11,2'b00,2'b00,1, 1,2'b10,0,2'b00,0,0); // single beat to port 1
        add(0,0,2'd0,2'b11,2'b10,2'b10,1, 0,2'b00,1,2'b10,0,1); // port 1 answers
        add(1,0,2'd0,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,0,0); // 4-beat to port 0
        add(1,0,2'd1,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,0,0); // dst toggles, ignored
        add(1,0,2'd1,2'b10,2'b00,2'b00,1, 0,2'b01,0,2'b00,0,0); // port 0 back-pressure
        add(1,0,2'd1,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,0,0);
        add(1,1,2'd1,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,0,0); // last, cnt=1
        add(1,1,2'd1,2'b11,2'b00,2'b00,1, 1,2'b10,0,2'b00,0,0); // back in IDLE, cnt=2
        add(1,0,2'd2,2'b11,2'b00,2'b00,1, 1,2'b00,0,2'b00,0,0); // bad dst -> DROP
        add(1,0,2'd0,2'b11,2'b00,2'b00,1, 1,2'b00,0,2'b00,1,0);
        add(1,1,2'd0,2'b11,2'b00,2'b00,1, 1,2'b00,0,2'b00,1,0); // drop ends
        add(0,0,2'd0,2'b11,2'b11,2'b00,1, 0,2'b00,1,2'b01,1,0); // both respond, port 0 wins
        add(0,0,2'd0,2'b11,2'b11,2'b10,1, 0,2'b00,1,2'b01,1,0); // lock holds port 0
        add(0,0,2'd0,2'b11,2'b11,2'b01,0, 0,2'b00,1,2'b00,1,0); // mem not ready
        add(0,0,2'd0,2'b11,2'b11,2'b01,1, 0,2'b00,1,2'b01,1,0); // last, cnt=1, ptr=1
        add(0,0,2'd0,2'b11,2'b01,2'b01,1, 0,2'b00,1,2'b01,1,0); // ptr 1 skips to 0, cnt=0
        for (int k = 0; k < 4; k++)
            add(1,1,2'd0,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,1,0); // cnt -> 4
        add(1,1,2'd0,2'b11,2'b00,2'b00,1, 0,2'b00,0,2'b00,1,0); // full: stall
        add(1,1,2'd0,2'b11,2'b01,2'b01,1, 0,2'b00,1,2'b01,1,0); // decrement does not release
        add(1,1,2'd0,2'b11,2'b00,2'b00,1, 1,2'b01,0,2'b00,1,0); // fifth accepted

        // Reset state
        do_reset();
        @(negedge clk_i);
        chk("rst fwd_ready", 64'(mem_fwd_ready_and_o), 64'd0);
        chk("rst acc_fwd_v", 64'(acc_fwd_v_o), 64'd0);
        chk("rst mem_rev_v", 64'(mem_rev_v_o), 64'd0);
        chk("rst acc_rev_ready", 64'(acc_rev_ready_and_o), 64'd0);
        chk("rst err", 64'(err_o), 64'd0);
        chk("rst stall_cnt", 64'(stall_cnt_o), 64'd0);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            mem_fwd_header_i    = {32'hF00D_0000, 32'(i)};
            mem_fwd_data_i      = {32'hDA7A_0000, 32'(i)};
            mem_fwd_v_i         = vecs[i].fv;
            mem_fwd_last_i      = vecs[i].fl;
            mem_fwd_dst_i       = vecs[i].dst;
            acc_fwd_ready_and_i = vecs[i].ar;
            acc_rev_v_i         = vecs[i].rv;
            acc_rev_last_i      = vecs[i].rl;
            mem_rev_ready_and_i = vecs[i].mr;
            @(negedge clk_i);
            chk($sformatf("v%0d fwd_ready", i), 64'(mem_fwd_ready_and_o), 64'(vecs[i].e_fr));
            chk($sformatf("v%0d acc_fwd_v", i), 64'(acc_fwd_v_o), 64'(vecs[i].e_av));
            chk($sformatf("v%0d mem_rev_v", i), 64'(mem_rev_v_o), 64'(vecs[i].e_mv));
            chk($sformatf("v%0d acc_rev_ready", i), 64'(acc_rev_ready_and_o), 64'(vecs[i].e_arr));
            chk($sformatf("v%0d err", i), 64'(err_o), 64'(vecs[i].e_err));
            chk($sformatf("v%0d hdr_bcast", i),
                64'(acc_fwd_header_o === {N{mem_fwd_header_i}}), 64'd1);
            if (vecs[i].e_mv) begin
                chk($sformatf("v%0d rev_hdr", i), mem_rev_header_o, rev_hdr(vecs[i].e_src));
                chk($sformatf("v%0d rev_last", i), 64'(mem_rev_last_o),
                    64'(vecs[i].rl[vecs[i].e_src]));
            end
            @(posedge clk_i);
            #1;
        end
        drive_idle();
        @(negedge clk_i);
        chk("stall_cnt total", 64'(stall_cnt_o), 64'(EXP_STALL));

        // Reset during beat 2 of a 4-beat message to port 1 (count was 4)
        do_reset();
        mem_fwd_v_i = 1'b1; mem_fwd_last_i = 1'b0; mem_fwd_dst_i = 2'd1;
        acc_fwd_ready_and_i = 2'b11;
        @(negedge clk_i);
        chk("mid beat0 acc_fwd_v", 64'(acc_fwd_v_o), 64'b10);
        @(posedge clk_i);
        #1 mem_fwd_dst_i = 2'd0;
        @(posedge clk_i);
        #1 reset_i = 1'b1;
        @(negedge clk_i);
        chk("mid rst acc_fwd_v", 64'(acc_fwd_v_o), 64'd0);
        chk("mid rst fwd_ready", 64'(mem_fwd_ready_and_o), 64'd0);
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        mem_fwd_v_i = 1'b0;
        @(negedge clk_i);
        chk("post rst acc_fwd_v", 64'(acc_fwd_v_o), 64'd0);
        chk("post rst mem_rev_v", 64'(mem_rev_v_o), 64'd0);
        @(posedge clk_i);
        #1 mem_fwd_v_i = 1'b1; mem_fwd_last_i = 1'b1; mem_fwd_dst_i = 2'd0;
        @(negedge clk_i);
        chk("post rst route acc_fwd_v", 64'(acc_fwd_v_o), 64'b01);
        chk("post rst route ready", 64'(mem_fwd_ready_and_o), 64'd1);
        @(posedge clk_i);

        // Two responses against one outstanding message: second underflows
        #1 drive_idle();
        acc_rev_v_i = 2'b01; acc_rev_last_i = 2'b01; mem_rev_ready_and_i = 1'b1;
        @(negedge clk_i);
        chk("uf resp1 mem_rev_v", 64'(mem_rev_v_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("uf resp2 err before", 64'(err_o), 64'd0);
        @(posedge clk_i);
        #1 drive_idle();
        @(negedge clk_i);
        chk("uf err sticky", 64'(err_o), 64'd1);
        @(posedge clk_i);

        // Continuous 2-beat responses on both ports
        do_reset();
        beat = 2'b00;
        acc_rev_v_i = 2'b11; mem_rev_ready_and_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            src = (k / 2) % 2;
            acc_rev_last_i = beat;
            @(negedge clk_i);
            chk($sformatf("rr%0d src", k), mem_rev_header_o, rev_hdr(src));
            chk($sformatf("rr%0d acc_rev_ready", k), 64'(acc_rev_ready_and_o), 64'(1 << src));
            chk($sformatf("rr%0d last", k), 64'(mem_rev_last_o), 64'(k % 2));
            beat[src] = ~beat[src];
            @(posedge clk_i);
            #1;
        end
        drive_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_sacc_mem_arbiter.md
BP_SACC_MEM_ARBITER -- requirements
Module: bp_sacc_mem_arbiter

Interface
REQ-001 Parameter num_acc_p, default 2: number of accelerator ports, from 2 to 8.
REQ-002 Parameter hdr_width_p, default 64: width of a BedRock mem header.
REQ-003 Parameter data_width_p, default 64: width of one stream beat.
REQ-004 Parameter max_outstanding_p, default 4: limit on forwarded messages not yet answered; sel_width_lp = clog2(num_acc_p).
REQ-005 clk_i, input, 1: the single clock; reset_i, input, 1: reset, synchronous and active-high.
REQ-006 mem_fwd_header_i / mem_fwd_data_i / mem_fwd_v_i / mem_fwd_last_i, input, hdr_width_p / data_width_p / 1 / 1: incoming forward stream beat.
REQ-007 mem_fwd_dst_i, input, sel_width_lp+1: decoded destination accelerator index, valid with mem_fwd_v_i.
REQ-008 mem_fwd_ready_and_o, output, 1: forward beat accepted.
REQ-009 acc_fwd_header_o / acc_fwd_data_o, output, num_acc_p*hdr_width_p / num_acc_p*data_width_p: per-port forward beat.
REQ-010 acc_fwd_v_o / acc_fwd_last_o, output, num_acc_p / num_acc_p: per-port valid and last; acc_fwd_ready_and_i, input, num_acc_p.
REQ-011 acc_rev_header_i / acc_rev_data_i / acc_rev_v_i / acc_rev_last_i, input, num_acc_p-wide arrays: per-port response beats.
REQ-012 acc_rev_ready_and_o, output, num_acc_p.
REQ-013 mem_rev_header_o / mem_rev_data_o / mem_rev_v_o / mem_rev_last_o, output, hdr_width_p / data_width_p / 1 / 1; mem_rev_ready_and_i, input, 1.
REQ-014 err_o, output, 1: sticky flag for a bad destination.
REQ-015 stall_cnt_o, output, 32: count of cycles the forward path stalled.

Function
REQ-016 The forward FSM SHALL have three states: IDLE, STREAM and DROP.
REQ-017 IDLE SHALL handle the first beat (v=1) as follows:
- mem_fwd_dst_i < num_acc_p: route the beat to that port combinationally, with zero-cycle latency.
- Handshake with last=0: latch the destination and go to STREAM.
- Otherwise: go to DROP as in REQ-019.
REQ-018 STREAM SHALL route all beats to the latched destination, ignoring mem_fwd_dst_i, and return to IDLE on a last-beat handshake.
REQ-019 A destination >= num_acc_p SHALL be handled as follows:
- Set err_o.
- Drive mem_fwd_ready_and_o=1 with no acc_fwd_v_o.
- Consume beats until the last beat, staying in or entering DROP.
- Do not increment the outstanding count.
REQ-020 mem_fwd_ready_and_o SHALL equal the selected port's acc_fwd_ready_and_i when routing, and SHALL be 0 when stalled.
REQ-021 Only one acc_fwd_v_o bit SHALL be high at a time, and header/data SHALL be broadcast to all ports.
REQ-022 The outstanding counter, width clog2(max_outstanding_p+1), SHALL follow these rules:
- Increment on a routed last-beat forward handshake.
- Decrement on a mem_rev last-beat handshake.
- Stay unchanged when both occur in the same cycle.
REQ-023 When the counter equals max_outstanding_p, IDLE SHALL stall new messages, STREAM SHALL continue, and a simultaneous decrement SHALL NOT release the stall in that cycle.
REQ-024 The reverse path SHALL use a round-robin arbiter over acc_rev_v_i, with priority starting at port 0 after reset.
REQ-025 The reverse grant SHALL lock from the first beat until the last-beat handshake, and the pointer SHALL then advance to granted+1 modulo num_acc_p.
REQ-026 acc_rev_ready_and_o SHALL be set only for the granted port, equal to mem_rev_ready_and_i, and the selected beat SHALL pass through with zero latency.
REQ-027 Counter underflow, meaning a response while the count is 0, SHALL saturate at 0 and set err_o.

Reset
REQ-028 Reset SHALL drive the FSM to IDLE, the counter to 0, the round-robin pointer to 0, the grant lock to unlocked, err_o to 0, stall_cnt_o to 0, and all v/ready outputs to 0.
REQ-029 Reset asserted mid-stream SHALL abandon the partial message on the next edge, with no beat emitted in that cycle.

Configuration
REQ-030 The macro BP_SACC_MEM_ARBITER_PERF_EN SHALL control stall counting:
- Defined: stall_cnt_o increments in each cycle with mem_fwd_v_i=1 and mem_fwd_ready_and_o=0, wrapping at 2^32.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are built.

Verification
REQ-031 Single-beat fwd with dst=1 and acc ready -> acc_fwd_v_o=2'b10 in the same cycle, counter goes to 1; acc1 returns one beat -> mem_rev_v_o=1, counter goes to 0.
REQ-032 4-beat fwd to port 0 while mem_fwd_dst_i toggles to 1 after beat 0 -> all 4 beats appear on port 0, FSM returns to IDLE after the last beat.
REQ-033 Five single-beat messages with no responses and max_outstanding_p=4 -> the fifth stalls with ready=0 (stall_cnt_o=1 per cycle if PERF_EN); one response -> the fifth is accepted the next cycle.
REQ-034 acc0 and acc1 each present 2-beat responses continuously -> output order acc0,acc0,acc1,acc1,acc0,... with no interleaving inside a message.
REQ-035 Fwd with dst=num_acc_p, 3 beats -> ready=1 for 3 cycles, no acc_fwd_v_o, err_o=1 sticky, counter unchanged.
REQ-036 reset_i pulsed during beat 2 of a 4-beat fwd -> outputs idle next cycle, counter 0, next message routed normally.
